// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer: loads user digits, counts down once per tick,
// pulses done and drives a tick-timed alarm when the count reaches 00:00.
module countdown_timer #(
   parameter int MIN_TENS_MAX = 5,
   parameter int ALARM_TICKS  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       set,
   input  logic [3:0] init_min_tens,
   input  logic [3:0] init_min_ones,
   input  logic [3:0] init_sec_tens,
   input  logic [3:0] init_sec_ones,
   input  logic       start_resume,
   input  logic       stop,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       expired,
   output logic       done,
   output logic       alarm
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   localparam int              CW         = $clog2(ALARM_TICKS + 1);
   localparam logic [CW-1:0]   ALARM_LAST = CW'(ALARM_TICKS - 1);
   localparam logic [3:0]      MT_MAX     = 4'(MIN_TENS_MAX);

   state_t        state_reg, state_next;
   logic [3:0]    min_tens_reg, min_tens_next;
   logic [3:0]    min_ones_reg, min_ones_next;
   logic [3:0]    sec_tens_reg, sec_tens_next;
   logic [3:0]    sec_ones_reg, sec_ones_next;
   logic          done_reg, done_next;
   logic          alarm_reg, alarm_next;
   logic [CW-1:0] alarm_cnt_reg, alarm_cnt_next;

   logic          is_zero, is_one;
   logic          borrow_so, borrow_st, borrow_mo;
   logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;

   function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   assign is_zero = (min_tens_reg == 4'd0) && (min_ones_reg == 4'd0) &&
                    (sec_tens_reg == 4'd0) && (sec_ones_reg == 4'd0);
   assign is_one  = (min_tens_reg == 4'd0) && (min_ones_reg == 4'd0) &&
                    (sec_tens_reg == 4'd0) && (sec_ones_reg == 4'd1);

   // Borrow ripples seconds-ones -> minutes-tens within a single edge.
   assign borrow_so = (sec_ones_reg == 4'd0);
   assign borrow_st = borrow_so && (sec_tens_reg == 4'd0);
   assign borrow_mo = borrow_st && (min_ones_reg == 4'd0);

   assign dec_so = borrow_so ? 4'd9 : sec_ones_reg - 4'd1;
   assign dec_st = !borrow_so ? sec_tens_reg :
                   (sec_tens_reg == 4'd0) ? 4'd5 : sec_tens_reg - 4'd1;
   assign dec_mo = !borrow_st ? min_ones_reg :
                   (min_ones_reg == 4'd0) ? 4'd9 : min_ones_reg - 4'd1;
   assign dec_mt = borrow_mo ? min_tens_reg - 4'd1 : min_tens_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         min_tens_reg  <= 4'd0;
         min_ones_reg  <= 4'd0;
         sec_tens_reg  <= 4'd0;
         sec_ones_reg  <= 4'd0;
         done_reg      <= 1'b0;
         alarm_reg     <= 1'b0;
         alarm_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         min_tens_reg  <= min_tens_next;
         min_ones_reg  <= min_ones_next;
         sec_tens_reg  <= sec_tens_next;
         sec_ones_reg  <= sec_ones_next;
         done_reg      <= done_next;
         alarm_reg     <= alarm_next;
         alarm_cnt_reg <= alarm_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      min_tens_next  = min_tens_reg;
      min_ones_next  = min_ones_reg;
      sec_tens_next  = sec_tens_reg;
      sec_ones_next  = sec_ones_reg;
      done_next      = 1'b0;
      alarm_next     = alarm_reg;
      alarm_cnt_next = alarm_cnt_reg;

      if (set) begin
         state_next     = IDLE;
         min_tens_next  = clamp(init_min_tens, MT_MAX);
         min_ones_next  = clamp(init_min_ones, 4'd9);
         sec_tens_next  = clamp(init_sec_tens, 4'd5);
         sec_ones_next  = clamp(init_sec_ones, 4'd9);
         alarm_next     = 1'b0;
         alarm_cnt_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!stop && start_resume && !is_zero)
                  state_next = RUN;
            end
            RUN: begin
               if (stop) begin
                  state_next = PAUSE;
               end else if (tick && !is_zero) begin
                  min_tens_next = dec_mt;
                  min_ones_next = dec_mo;
                  sec_tens_next = dec_st;
                  sec_ones_next = dec_so;
                  if (is_one) begin
                     state_next     = EXPIRED;
                     done_next      = 1'b1;
                     alarm_next     = 1'b1;
                     alarm_cnt_next = '0;
                  end
               end
            end
            PAUSE: begin
               if (!stop && start_resume)
                  state_next = RUN;
            end
            EXPIRED: begin
               // stop acknowledges the alarm; otherwise count ticks until it times out.
               if (stop) begin
                  state_next     = IDLE;
                  alarm_next     = 1'b0;
                  alarm_cnt_next = '0;
               end else if (tick && alarm_reg) begin
                  alarm_cnt_next = alarm_cnt_reg + 1'b1;
                  if (alarm_cnt_reg == ALARM_LAST)
                     alarm_next = 1'b0;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      running  = (state_reg == RUN);
      expired  = (state_reg == EXPIRED);
      done     = done_reg;
      alarm    = alarm_reg;
      min_tens = min_tens_reg;
      min_ones = min_ones_reg;
      sec_tens = sec_tens_reg;
      sec_ones = sec_ones_reg;
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed table-driven bench for countdown_timer plus an async reset sequence.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick, set, start_resume, stop;
   logic [3:0] init_min_tens, init_min_ones, init_sec_tens, init_sec_ones;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, expired, done, alarm;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        s;
      logic [15:0] init;
      logic        sr;
      logic        sp;
      logic        tk;
      logic [15:0] exp_cnt;
      logic [3:0]  exp_flags;   // {running, expired, done, alarm}
   } vec_t;

   vec_t vecs[$];

   countdown_timer #(.MIN_TENS_MAX(5), .ALARM_TICKS(4)) dut (
      .clk(clk), .reset(reset), .tick(tick), .set(set),
      .init_min_tens(init_min_tens), .init_min_ones(init_min_ones),
      .init_sec_tens(init_sec_tens), .init_sec_ones(init_sec_ones),
      .start_resume(start_resume), .stop(stop),
      .min_tens(min_tens), .min_ones(min_ones),
      .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .expired(expired), .done(done), .alarm(alarm)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic s, input logic [15:0] init,
                               input logic sr, input logic sp, input logic tk,
                               input logic [15:0] exp_cnt, input logic [3:0] exp_flags);
      vec_t v;
      v.s = s; v.init = init; v.sr = sr; v.sp = sp; v.tk = tk;
      v.exp_cnt = exp_cnt; v.exp_flags = exp_flags;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] want_cnt, input logic [3:0] want_flags);
      logic [15:0] got_cnt;
      logic [3:0]  got_flags;
      got_cnt   = {min_tens, min_ones, sec_tens, sec_ones};
      got_flags = {running, expired, done, alarm};
      n_cmp++;
      if (got_cnt !== want_cnt) begin
         n_bad++;
         $display("FAIL %s digits: got %h want %h", name, got_cnt, want_cnt);
      end
      n_cmp++;
      if (got_flags !== want_flags) begin
         n_bad++;
         $display("FAIL %s flags{run,exp,done,alarm}: got %b want %b", name, got_flags, want_flags);
      end
   endtask

   task automatic drive(input logic s, input logic [15:0] init, input logic sr,
                        input logic sp, input logic tk);
      set = s; start_resume = sr; stop = sp; tick = tk;
      {init_min_tens, init_min_ones, init_sec_tens, init_sec_ones} = init;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 16'h0000, 0, 0, 0);
      step();
      step();
      check("reset_state", 16'h0000, 4'b0000);
      reset = 1'b1;

      // Load 12:34, start running, then drop reset between edges.
      drive(1, 16'h1234, 0, 0, 0);
      step();
      drive(0, 16'h0000, 1, 0, 0);
      step();
      check("load_1234_run", 16'h1234, 4'b1000);
      drive(0, 16'h0000, 0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", 16'h0000, 4'b0000);
      step();
      reset = 1'b1;
      step();
      check("after_reset", 16'h0000, 4'b0000);
      $display("reset sequence: digits %h%h%h%h", min_tens, min_ones, sec_tens, sec_ones);

      vecs.push_back(mk(1, 16'h1000, 0, 0, 0, 16'h1000, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h1000, 4'b1000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0959, 4'b1000));
      vecs.push_back(mk(1, 16'h0002, 0, 0, 0, 16'h0002, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0002, 4'b1000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0001, 4'b1000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 4'b0111));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0000, 4'b0101));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 4'b0101));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 4'b0101));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 4'b0101));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 4'b0100));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 4'b0100));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 4'b0100));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 4'b0000));
      vecs.push_back(mk(1, 16'h0005, 0, 0, 0, 16'h0005, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0005, 4'b1000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0004, 4'b1000));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h0004, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0004, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0004, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0004, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0004, 4'b1000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0003, 4'b1000));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0003, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0003, 4'b0000));
      vecs.push_back(mk(1, 16'h7F9C, 0, 0, 0, 16'h5959, 4'b0000));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 4'b0000));
      vecs.push_back(mk(1, 16'h0001, 0, 0, 0, 16'h0001, 4'b0000));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0001, 4'b1000));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 4'b0111));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 4'b0000));

      foreach (vecs[i]) begin
         drive(vecs[i].s, vecs[i].init, vecs[i].sr, vecs[i].sp, vecs[i].tk);
         step();
         check($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_flags);
         $display("vec%0d set=%b sr=%b sp=%b tk=%b -> %h%h:%h%h run=%b exp=%b done=%b alarm=%b",
                  i, vecs[i].s, vecs[i].sr, vecs[i].sp, vecs[i].tk,
                  min_tens, min_ones, sec_tens, sec_ones, running, expired, done, alarm);
      end

      // Stop coincident with the expiring tick: pause at 00:01, no done pulse.
      drive(1, 16'h0001, 0, 0, 0);
      step();
      drive(0, 16'h0000, 1, 0, 0);
      step();
      drive(0, 16'h0000, 0, 1, 1);
      step();
      check("stop_beats_last_tick", 16'h0001, 4'b0000);
      drive(0, 16'h0000, 0, 0, 0);
      step();
      check("no_late_done", 16'h0001, 4'b0000);
      $display("stop/tick sequence: digits %h%h%h%h done=%b", min_tens, min_ones, sec_tens, sec_ones, done);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Watch-controller countdown timer: a BCD MM:SS down-counter that runs in the opposite direction to the stopwatch up-counters.
- Loaded from user-set digits, decremented once per 1 Hz tick with borrow rippling seconds-ones -> seconds-tens -> minutes-ones -> minutes-tens.
- Raises a one-cycle done pulse and a tick-timed alarm on reaching 00:00.
- Sits beside the stopwatch chain and feeds the same digit display mux.

Parameters:
- MIN_TENS_MAX, 5, largest legal minutes-tens digit (max count 59:59).
- ALARM_TICKS, 4, number of ticks the alarm output stays high after expiry.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-clk-wide 1 Hz enable pulse.
- set  input  1  load init digits.
- init_min_tens  input  4  load value, minutes tens.
- init_min_ones  input  4  load value, minutes ones.
- init_sec_tens  input  4  load value, seconds tens.
- init_sec_ones  input  4  load value, seconds ones.
- start_resume  input  1  level request to start or resume counting.
- stop  input  1  level request to pause, or to acknowledge the alarm.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  current BCD count.
- running  output  1  high while in RUN.
- expired  output  1  high while in EXPIRED.
- done  output  1  one-clk pulse on reaching 00:00.
- alarm  output  1  alarm drive.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: all digits 0, state IDLE, running=0, expired=0, done=0, alarm=0, alarm tick counter 0.
- Output timing: all outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Per-edge priority: reset > set > stop > start_resume > tick.
- set (any state):
  - load the four init digits and go to IDLE; clears done, alarm and alarm counter.
  - out-of-range digits clamp on load: ones digits >9 load 9, sec_tens >5 loads 5, min_tens >MIN_TENS_MAX loads MIN_TENS_MAX.
- IDLE:
  - start_resume=1 with count != 00:00 -> RUN.
  - start_resume=1 with count == 00:00 -> stay IDLE.
  - tick is ignored.
- RUN:
  - stop=1 -> PAUSE; any tick in the same cycle is dropped.
  - otherwise on tick, decrement by one second:
    - sec_ones 0 -> 9 with borrow, else -1.
    - sec_tens 0 -> 5 with borrow on borrow-in, else -1.
    - min_ones 0 -> 9 with borrow on borrow-in, else -1.
    - min_tens -1 on borrow-in.
  - The tick that moves 00:01 -> 00:00 also moves state to EXPIRED and sets done=1 for exactly the following clk cycle.
- PAUSE:
  - digits hold; tick is ignored.
  - start_resume=1 (with stop=0) -> RUN.
  - First decrement happens on the first tick after the transition edge; a tick coincident with the transition is dropped.
- EXPIRED:
  - digits hold 00:00; expired=1.
  - alarm=1 from entry until ALARM_TICKS ticks have been counted, then 0; state remains EXPIRED.
  - stop=1 -> IDLE, alarm cleared immediately (acknowledge).
  - start_resume is ignored.
- No underflow: 00:00 is never decremented.
- Stay in range: digits always remain legal BCD in range.
- running / expired: running equals (state==RUN); expired equals (state==EXPIRED).
- Reset mid-count: asynchronous clear to reset values; no done pulse is produced.
- Stop and start_resume together: stop wins (RUN -> PAUSE, PAUSE stays PAUSE, IDLE stays IDLE).

Test Plan:
- Reset with digits loaded at 12:34 -> all outputs 0 asynchronously, before the next clk edge; state IDLE.
- set with init 1,0,0,0 (10:00), start_resume, 1 tick -> 09:59; the 10:00 -> 09:59 borrow ripples through all four digits in one edge.
- set 00:02, start, 2 ticks -> 00:01 then 00:00; done high exactly 1 cycle; expired=1; alarm high for 4 ticks then low; a 3rd tick leaves 00:00.
- Load 00:05, start, 1 tick -> 00:04; stop with tick in the same cycle -> PAUSE at 00:04; 3 ticks -> still 00:04; start_resume -> first subsequent tick gives 00:03.
- set with init 7,F,9,C -> loads 5,9,5,9 (59:59); start with count 00:00 -> stays IDLE, running=0.
- In EXPIRED with alarm high, assert stop -> IDLE and alarm=0 next cycle; start_resume and stop asserted together in RUN -> PAUSE.
